vdc_sng_array: RTL

Multi-channel, parametrised Van der Corput (VDC) stochastic number generator for the HDC encoder datapath. A single bit-reversed counter drives CHANNELS comparators. Each comparator turns a latched WIDTH-bit scalar into a unary bitstream of exactly 2^WIDTH bits. The block adds a start/done frame, a valid/ready output handshake with back-pressure, and a per-channel ones counter that reports the stream's exact value at frame end.

---
 rtl/vdc_pkg.sv | 25 ++
 rtl/vdc_bitrev.sv | 13 +
 rtl/vdc_sng_array.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vdc_pkg.sv
// Shared types and constants for the Van der Corput stochastic number generator.
// Legal ranges: WIDTH 2..16, CHANNELS 1..64.
package vdc_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam int unsigned WIDTH_MIN    = 2;
    localparam int unsigned WIDTH_MAX    = 16;
    localparam int unsigned CHANNELS_MIN = 1;
    localparam int unsigned CHANNELS_MAX = 64;

    // Reverses the low `width` bits of value; bit 0 becomes bit width-1.
    function automatic logic [WIDTH_MAX-1:0] bit_reverse(input logic [WIDTH_MAX-1:0] value,
                                                         input int unsigned width);
        logic [WIDTH_MAX-1:0] result;
        result = '0;
        for (int unsigned b = 0; b < WIDTH_MAX; b++) begin
            if (b < width) begin
                result[width-1-b] = value[b];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vdc_bitrev.sv
// Combinational WIDTH-bit reversal: input bit 0 drives output MSB.
module vdc_bitrev #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        assign o_value[g] = i_value[WIDTH-1-g];
    end

endmodule

// File: rtl/vdc_sng_array.sv
// Multi-channel VDC stochastic number generator with start/done framing and valid/ready output.
// Optional per-channel XOR scramble of the shared sequence: define VDC_SCRAMBLE_EN.
module vdc_sng_array
    import vdc_pkg::*;
#(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [CHANNELS*WIDTH-1:0] i_scalar,
    input  logic [CHANNELS*WIDTH-1:0] i_scramble,
    output logic                      o_busy,
    output logic [CHANNELS-1:0]       o_bs,
    output logic                      o_bs_valid,
    input  logic                      i_bs_ready,
    output logic                      o_done,
    output logic [CHANNELS*WIDTH-1:0] o_ones
);

    state_t                    r_state;
    logic [WIDTH-1:0]          r_count;
    logic [CHANNELS*WIDTH-1:0] r_scalar;
    logic                      r_busy;
    logic                      r_valid;
    logic                      r_done;

    logic                      w_accept;
    logic                      w_xfer;
    logic [WIDTH-1:0]          w_vdc;
    logic [CHANNELS-1:0]       w_cmp;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_xfer   = r_valid && i_bs_ready;

    vdc_bitrev #(
        .WIDTH (WIDTH)
    ) u_bitrev (
        .i_value (r_count),
        .o_value (w_vdc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= StRun;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                StRun: begin
                    if (w_xfer) begin
                        // Natural wrap returns count to 0 after the last bit.
                        r_count <= r_count + WIDTH'(1);
                        if (r_count == '1) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_scalar <= i_scalar;
        end
    end

`ifndef VDC_SCRAMBLE_EN
    logic w_unused_scramble;
    assign w_unused_scramble = ^i_scramble;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] w_v;
        logic [WIDTH-1:0] r_ones;

`ifdef VDC_SCRAMBLE_EN
        logic [WIDTH-1:0] r_mask;

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_mask <= i_scramble[g*WIDTH +: WIDTH];
            end
        end

        assign w_v = w_vdc ^ r_mask;
`else
        assign w_v = w_vdc;
`endif

        assign w_cmp[g] = r_scalar[g*WIDTH +: WIDTH] > w_v;

        always_ff @(posedge clk) begin
            if (reset || w_accept) begin
                r_ones <= '0;
            end else if (w_xfer) begin
                r_ones <= r_ones + {{(WIDTH-1){1'b0}}, w_cmp[g]};
            end
        end

        assign o_ones[g*WIDTH +: WIDTH] = r_ones;
    end

    // Gating by valid keeps bs at 0 outside RUN without touching the compare path.
    assign o_bs       = r_valid ? w_cmp : '0;
    assign o_busy     = r_busy;
    assign o_bs_valid = r_valid;
    assign o_done     = r_done;

endmodule
